// File: rtl/add_scheduler_if.sv
// add_scheduler_if: request, response and Add4 slice signals
// of the shared-adder scheduler, with environment/scheduler views.
interface add_scheduler_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_ci;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_ci;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_ci;
   logic [3:0]   add_sum;
   logic         add_cout;

   modport master (
      output req0_valid, req0_a, req0_b, req0_ci,
      output req1_valid, req1_a, req1_b, req1_ci,
      output rsp_ready, add_sum, add_cout,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
      input  add_a, add_b, add_ci
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ci,
      input  req1_valid, req1_a, req1_b, req1_ci,
      input  rsp_ready, add_sum, add_cout,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout,
      output add_a, add_b, add_ci
   );
endinterface

// File: rtl/add_scheduler.sv
// add_scheduler: round-robin sharing of one 4-bit Add4 slice between
// two requesters, one nibble per cycle, LSB first, with a carry register.
module add_scheduler #(
   parameter int NIBBLES = 4
) (
   input logic            clk,
   input logic            rst_n,
   add_scheduler_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [KW-1:0] k;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  sum_reg;
   logic          ci_reg;
   logic          id_reg;
   logic          carry_reg;
   logic          cout_reg;
   logic          last_id;
   logic          grant;
   logic          accept;
   logic          last_nib;

   // A lone requester wins; on a tie the one not served last wins.
   assign grant = bus.req1_valid & (~bus.req0_valid | ~last_id);

   assign bus.req0_ready = (state == IDLE) & ~grant & rst_n;
   assign bus.req1_ready = (state == IDLE) & grant & rst_n;

   assign accept = (bus.req0_valid & bus.req0_ready)
                 | (bus.req1_valid & bus.req1_ready);
   assign last_nib = (k == K_LAST);

   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_sum   = sum_reg;
   assign bus.rsp_cout  = cout_reg;
   assign bus.rsp_id    = id_reg;

   // Next-state logic of the IDLE/RUN/RESP sequencer.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last_nib) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Present the current nibble to the slice; idle the slice otherwise.
   always_comb begin
      bus.add_a  = 4'h0;
      bus.add_b  = 4'h0;
      bus.add_ci = 1'b0;
      if (state == RUN) begin
         bus.add_a  = a_reg[{k, 2'b00} +: 4];
         bus.add_b  = b_reg[{k, 2'b00} +: 4];
         bus.add_ci = (k == '0) ? ci_reg : carry_reg;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, nibble accumulation and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         ci_reg    <= 1'b0;
         id_reg    <= 1'b0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         last_id   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_reg  <= grant ? bus.req1_a : bus.req0_a;
                  b_reg  <= grant ? bus.req1_b : bus.req0_b;
                  ci_reg <= grant ? bus.req1_ci : bus.req0_ci;
                  id_reg <= grant;
                  k      <= '0;
               end
            end
            RUN: begin
               sum_reg[{k, 2'b00} +: 4] <= bus.add_sum;
               carry_reg <= bus.add_cout;
               k         <= k + 1'b1;
               if (last_nib) cout_reg <= bus.add_cout;
            end
            RESP: begin
               if (bus.rsp_ready) last_id <= id_reg;
            end
            default: ;
         endcase
      end
   end
endmodule
